// File: rtl/div_nonrestoring_if.sv
// Handshake and result bundle for the iterative signed divider.
// The master issues ctrl_div with its operands. The slave returns the
// quotient, the remainder, the divide-by-zero flag and its status.
interface div_nonrestoring_if #(
   parameter int WIDTH = 32
);
   logic             ctrl_div;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             exception;
   logic             result_rdy;
   logic             busy;

   modport master (
      output ctrl_div, dividend, divisor,
      input  quotient, remainder, exception, result_rdy, busy
   );

   modport slave (
      input  ctrl_div, dividend, divisor,
      output quotient, remainder, exception, result_rdy, busy
   );
endinterface

// File: rtl/div_nonrestoring.sv
// Iterative signed integer divider using the non-restoring algorithm.
// It resolves one quotient bit per clock. The division works on operand
// magnitudes, and the signs are applied in a final fix-up cycle.
// Latency from accept to result_rdy is WIDTH+1 edges.
// Divide-by-zero is flagged one edge after accept.
module div_nonrestoring #(
   parameter int WIDTH = 32
) (
   input logic                clock,
   input logic                reset_n,
   div_nonrestoring_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);

   // S_DZ is a one-cycle, non-busy holding state for divide-by-zero.
   // It makes the zero result appear one edge after accept.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_FIX  = 3'd2,
      S_DONE = 3'd3,
      S_DZ   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic signed [WIDTH:0] p_q, p_d;      // partial remainder, one guard bit
   logic [WIDTH-1:0]    q_q, q_d;        // dividend magnitude shifting out, quotient bits in
   logic [WIDTH:0]      d_q, d_d;        // divisor magnitude, always non-negative
   logic                qsign_q, qsign_d;
   logic                rsign_q, rsign_d;
   logic [WIDTH-1:0]    quo_q, quo_d;
   logic [WIDTH-1:0]    rem_q, rem_d;
   logic                exc_q, exc_d;
   logic                rdy_q, rdy_d;
   logic                busy_q, busy_d;

   logic                accepting;
   logic [WIDTH-1:0]    dvd_mag;
   logic [WIDTH:0]      dvs_ext;
   logic [WIDTH:0]      dvs_mag;
   logic signed [WIDTH:0] p_shift;
   logic signed [WIDTH:0] p_step;
   logic [WIDTH-1:0]    rem_mag;

   assign accepting = (state_q == S_IDLE) || (state_q == S_DONE);

   // In WIDTH bits, negating the most negative value returns the same bit pattern.
   // Read as unsigned, that pattern is +2^(WIDTH-1), which is the correct magnitude.
   assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
   assign dvs_ext = {bus.divisor[WIDTH-1], bus.divisor};
   assign dvs_mag = dvs_ext[WIDTH] ? -dvs_ext : dvs_ext;

   // One non-restoring step: shift {P,Q} left, then subtract or add D by the sign of P.
   // The guard bit keeps 2P in range, so the shift keeps the sign of the old P.
   assign p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign p_step  = p_shift[WIDTH] ? (p_shift + $signed(d_q)) : (p_shift - $signed(d_q));

   // Final correction. A negative partial remainder gets D added back.
   // Only the low WIDTH bits are kept; the true remainder is non-negative and below D.
   assign rem_mag = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q[WIDTH-1:0]) : p_q[WIDTH-1:0];

   // State and datapath registers; asynchronous reset abandons any division in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         count_q <= '0;
         p_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         p_q     <= p_d;
         q_q     <= q_d;
         d_q     <= d_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and datapath update; result registers hold unless a result is produced
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      p_d     = p_q;
      q_d     = q_q;
      d_d     = d_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accepting && bus.ctrl_div) begin
               count_d = '0;
               p_d     = '0;
               qsign_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
               rsign_d = bus.dividend[WIDTH-1];
               d_d     = dvs_mag;
               if (bus.divisor == '0) begin
                  // Keep the raw dividend; it becomes the remainder.
                  q_d     = bus.dividend;
                  state_d = S_DZ;
               end else begin
                  q_d     = dvd_mag;
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            p_d = p_step;
            q_d = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
            if (count_q == CW'(WIDTH - 1)) begin
               count_d = '0;
               state_d = S_FIX;
            end else begin
               count_d = count_q + CW'(1);
            end
         end

         S_FIX: begin
            p_d     = {1'b0, rem_mag};
            quo_d   = qsign_q ? -q_q : q_q;
            rem_d   = rsign_q ? -rem_mag : rem_mag;
            exc_d   = 1'b0;
            rdy_d   = 1'b1;
            state_d = S_DONE;
         end

         S_DZ: begin
            quo_d   = '0;
            rem_d   = q_q;
            exc_d   = 1'b1;
            rdy_d   = 1'b1;
            state_d = S_DONE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_FIX);
   end

   assign bus.quotient   = quo_q;
   assign bus.remainder  = rem_q;
   assign bus.exception  = exc_q;
   assign bus.result_rdy = rdy_q;
   assign bus.busy       = busy_q;

endmodule
